// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write-side and TX-stage signals of the UART transmit byte FIFO
interface uart_tx_fifo_if #(parameter int ADDR_W = 4);
  logic              i_Wr_DV;
  logic [7:0]        i_Wr_Byte;
  logic              o_Full;
  logic              o_Empty;
  logic [ADDR_W:0]   o_Count;
  logic              o_Overflow;
  logic              o_Tx_DV;
  logic [7:0]        o_Tx_Byte;
  logic              i_Tx_Active;
  logic              i_Tx_Done;
  modport slave (
    input  i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
    output o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte
  );
  modport master (
    output i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
    input  o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 16-deep byte FIFO that launches bytes one at a time into the UART TX stage
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic           clk,
  input logic           i_Rst_n,
  uart_tx_fifo_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  state_t            state_q;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, dv_q;
  logic [7:0]        byte_q;
  logic              full, empty, wr_ok, pop;
  // Full is judged before any same-cycle pop, so a pop never rescues a write at full
  assign full  = count_q == CNT_FULL;
  assign empty = count_q == '0;
  assign wr_ok = bus.i_Wr_DV && !full;
  assign pop   = state_q == IDLE && !empty && !bus.i_Tx_Active;
  always_comb begin
    wr_d    = wr_ok ? wr_q + PTR_ONE : wr_q;
    rd_d    = pop ? rd_q + PTR_ONE : rd_q;
    count_d = (wr_ok && !pop) ? count_q + CNT_ONE :
              (pop && !wr_ok) ? count_q - CNT_ONE : count_q;
  end
  always_ff @(posedge clk)
    if (wr_ok) mem_q[wr_q] <= bus.i_Wr_Byte;
  always_ff @(posedge clk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= bus.i_Wr_DV && full;
    end
  always_ff @(posedge clk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      state_q <= IDLE;
      dv_q    <= 1'b0;
      byte_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          state_q <= LAUNCH;
          dv_q    <= 1'b1;
          byte_q  <= mem_q[rd_q];
        end
        LAUNCH: begin
          state_q <= BUSY;
          dv_q    <= 1'b0;
        end
        BUSY:    state_q <= bus.i_Tx_Done ? IDLE : BUSY;
        default: state_q <= IDLE;
      endcase
    end
  assign bus.o_Full     = full;
  assign bus.o_Empty    = empty;
  assign bus.o_Count    = count_q;
  assign bus.o_Overflow = ovf_q;
  assign bus.o_Tx_DV    = dv_q;
  assign bus.o_Tx_Byte  = byte_q;
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-buffering front end for the UART transmitter. It accepts bytes from the system side at up to one per clock, holds them in a 16-entry FIFO, and drains them one at a time into the UART TX stage. It drives the TX stage's data-valid/byte inputs and paces itself off the TX stage's active/done outputs. It sits directly upstream of `uart_top`'s `i_DV`/`i_Byte` inputs and removes the need for callers to wait on `o_Sig_Done` between bytes.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of two.
- `ADDR_W`, 4: log2(`DEPTH`).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `i_Rst_n`  in  1  asynchronous, active-low reset.
- `i_Wr_DV`  in  1  write strobe; one byte per cycle when high.
- `i_Wr_Byte`  in  8  byte to enqueue.
- `o_Full`  out  1  FIFO holds `DEPTH` bytes.
- `o_Empty`  out  1  FIFO holds 0 bytes.
- `o_Count`  out  ADDR_W+1  current occupancy, 0..`DEPTH`.
- `o_Overflow`  out  1  one-cycle pulse when a write is dropped.
- `o_Tx_DV`  out  1  one-cycle launch strobe to the TX `i_DV`.
- `o_Tx_Byte`  out  8  byte to the TX `i_Byte`; held stable between launches.
- `i_Tx_Active`  in  1  TX `o_Sig_Active`.
- `i_Tx_Done`  in  1  TX `o_Sig_Done`, a one-cycle pulse at the end of the stop bit.

## Operation
- Storage: `DEPTH`×8 register array with write pointer, read pointer (`ADDR_W` bits, natural wrap), and an `ADDR_W+1`-bit count. `o_Full` = (count==`DEPTH`). `o_Empty` = (count==0).
- Write: accepted iff `i_Wr_DV` && !`o_Full` at the sampling edge. The byte is stored at the write pointer and the write pointer increments.
- Dropped write: if `i_Wr_DV` && `o_Full`, the byte is discarded, `o_Overflow`=1 for the next cycle, and pointers and count are unchanged. A same-cycle pop does not make room for that write; full is evaluated before the pop.
- Launcher FSM, states IDLE, LAUNCH, BUSY:
  - IDLE → LAUNCH when !`o_Empty` && !`i_Tx_Active`. On that edge: read the head into `o_Tx_Byte`, increment the read pointer, and set `o_Tx_DV`=1.
  - LAUNCH → BUSY unconditionally. `o_Tx_DV` returns to 0, so it is exactly one cycle wide.
  - BUSY → IDLE on `i_Tx_Done`=1. Otherwise stay in BUSY.
- Count update: +1 on an accepted write only; −1 on a pop only; unchanged when both happen in the same cycle.
- Simultaneous write and pop at count==1: the pop takes the old head, the new byte is stored, and count stays 1.
- Reset (asynchronous, any state, including mid-frame):
  - Pointers and count go to 0 and the FSM goes to IDLE.
  - Outputs: `o_Tx_DV`=0, `o_Tx_Byte`=8'h00, `o_Overflow`=0, `o_Empty`=1, `o_Full`=0, `o_Count`=0.
  - Array contents are don't-care. A frame already in the TX stage is not aborted by this block.
- After reset release in IDLE, a stale `i_Tx_Done` is harmless. Launch is gated by `i_Tx_Active`.

## Timing
- Write-to-launch latency, from an empty FIFO with TX idle: write sampled at edge N → `o_Empty`=0 after N → `o_Tx_DV`=1 and `o_Tx_Byte` valid after edge N+1 → `o_Tx_DV`=0 after N+2.
- Back-to-back frames: `i_Tx_Done` at edge M returns the FSM to IDLE. The next `o_Tx_DV` follows edge M+1, provided `i_Tx_Active` is already 0.
- With `CLKS_PER_BIT`=87, a 10-bit frame is 870 clocks, so n queued bytes drain in about n×872 clocks.
- Flag and count outputs are registered and update on the edge after the causing event.
- No combinational path exists from `i_Wr_*` or `i_Tx_*` to any output.

## Test plan
1. Single byte: reset, then write 8'hC3 → `o_Tx_DV` one cycle high two edges later with `o_Tx_Byte`=C3. Count goes 0→1→0. Loopback `uart_top` `o_Byte`=C3.
2. Burst: write C3, 5A, A5 on consecutive cycles → `o_Count` peaks at 2. Exactly three `o_Tx_DV` pulses, each at least 870 clocks apart. RX receives C3, 5A, A5 in order.
3. Fill and overflow: hold `i_Tx_Active`=1 (TX stubbed busy) and write 0x00..0x10 (17 bytes) → `o_Full`=1 at count 16. A single `o_Overflow` pulse on the 17th. After release, 0x00..0x0F drain in order and 0x10 is never sent.
4. Concurrent write and pop: with count==1 and TX idle, write 8'h7E on the launch cycle → count stays 1, and 7E launches after the next `i_Tx_Done`.
5. Reset mid-operation: queue 4 bytes and assert `i_Rst_n`=0 during the second frame → all outputs reach their reset values immediately. No further `o_Tx_DV` after release until a new write occurs.
6. Wrap-around: 40 bytes written in bursts of 10 with drains in between → all 40 are received in order, with no loss and no duplication across the pointer wrap.
